// File: rtl/buffer_row_packer.sv
// Packs TOTAL_INPUT narrow stream words into one bank row and hands rows
// to the bank write side with frame tracking and framing error flags.
module buffer_row_packer #(
    parameter int IN_WIDTH    = 64,
    parameter int TOTAL_INPUT = 4,
    parameter int TOTAL_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [IN_WIDTH-1:0]                 s_data,
    input  logic                                s_valid,
    input  logic                                s_last,
    output logic                                s_ready,
    output logic [TOTAL_INPUT*IN_WIDTH-1:0]     row_data,
    output logic                                row_valid,
    input  logic                                row_ready,
    output logic                                row_last,
    output logic [$clog2(TOTAL_DEPTH)-1:0]      row_idx,
    output logic                                frame_done,
    output logic                                err_short,
    output logic                                err_long
);

    localparam int ROW_W  = TOTAL_INPUT * IN_WIDTH;
    localparam int LANE_W = $clog2(TOTAL_INPUT);
    localparam int IDX_W  = $clog2(TOTAL_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(TOTAL_INPUT - 1);
    localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(TOTAL_DEPTH - 1);

    logic [ROW_W-1:0]  asm_data_q, asm_data_d;
    logic              asm_full_q, asm_full_d;
    logic [IDX_W-1:0]  asm_idx_q, asm_idx_d;
    logic              asm_last_q, asm_last_d;
    logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [IDX_W-1:0]  row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              frame_done_q, frame_done_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;

    logic             out_free;
    logic             s_fire;
    logic             at_lane_end;
    logic             at_row_end;
    logic             row_done;
    logic             frame_end;
    logic [ROW_W-1:0] merged;

    assign out_free = !out_valid_q || row_ready;
    assign s_ready  = rst_n && !(asm_full_q && !out_free);
    assign s_fire   = s_valid && s_ready;

    always_comb begin
        asm_data_d   = asm_data_q;
        asm_full_d   = asm_full_q;
        asm_idx_d    = asm_idx_q;
        asm_last_d   = asm_last_q;
        lane_cnt_d   = lane_cnt_q;
        row_cnt_d    = row_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_idx_d    = out_idx_q;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;
        at_lane_end  = (lane_cnt_q == LAST_LANE);
        at_row_end   = (row_cnt_q == LAST_ROW);
        row_done     = at_lane_end || s_last;
        frame_end    = s_last || (at_lane_end && at_row_end);
        merged       = '0;
        frame_done_d = out_valid_q && row_ready && out_last_q;

        if (out_valid_q && row_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // A held full assembly takes priority for the freed output slot
        if (asm_full_q && out_free) begin
            out_data_d  = asm_data_q;
            out_idx_d   = asm_idx_q;
            out_last_d  = asm_last_q;
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
            asm_data_d  = '0;
        end

        if (s_fire) begin
            merged = asm_data_d;
            merged[lane_cnt_q*IN_WIDTH +: IN_WIDTH] = s_data;
            if (s_last && !(at_lane_end && at_row_end)) begin
                err_short_d = 1'b1;
            end
            if (at_lane_end && at_row_end && !s_last) begin
                err_long_d = 1'b1;
            end
            if (row_done) begin
                lane_cnt_d = '0;
                row_cnt_d  = frame_end ? '0 : row_cnt_q + 1'b1;
                if (out_free && !asm_full_q) begin
                    out_data_d  = merged;
                    out_idx_d   = row_cnt_q;
                    out_last_d  = frame_end;
                    out_valid_d = 1'b1;
                    asm_data_d  = '0;
                end else begin
                    asm_data_d = merged;
                    asm_full_d = 1'b1;
                    asm_idx_d  = row_cnt_q;
                    asm_last_d = frame_end;
                end
            end else begin
                asm_data_d = merged;
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_data_q   <= '0;
            asm_full_q   <= 1'b0;
            asm_idx_q    <= '0;
            asm_last_q   <= 1'b0;
            lane_cnt_q   <= '0;
            row_cnt_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            asm_data_q   <= asm_data_d;
            asm_full_q   <= asm_full_d;
            asm_idx_q    <= asm_idx_d;
            asm_last_q   <= asm_last_d;
            lane_cnt_q   <= lane_cnt_d;
            row_cnt_q    <= row_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign row_data   = out_data_q;
    assign row_valid  = out_valid_q;
    assign row_last   = out_last_q;
    assign row_idx    = out_idx_q;
    assign frame_done = frame_done_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule
